// File: rtl/apb_global_pkg.sv
// rtl/apb_global_pkg.sv - shared APB bus constants and slave FSM state type
// Holds the bus-wide default widths, the completer FSM encoding and the
// upper bound on configurable wait states.
package apb_global_pkg;

    localparam int ADDRESS_WIDTH   = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int NO_OF_SLAVES    = 1;

    // Largest pready-low stretch a completer may be configured for.
    localparam int MAX_WAIT_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apb_slave_state_e;

endpackage

// File: rtl/apb_slave_mem_array.sv
// rtl/apb_slave_mem_array.sv - byte-strobed word array with combinational read
// Ports:
//   clk, rst            clock, synchronous active-high clear of every word
//   we, widx            write enable and word index
//   wdata, wstrb        write data and per-byte lane enables
//   ridx, rdata         combinational read index and data (0 when out of range)
module apb_slave_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16,
    parameter int IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(widx) < 32'(MEM_DEPTH))) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Non-power-of-two depths leave unused index codes; those read as zero.
    always_comb begin
        rdata = '0;
        if (32'(ridx) < 32'(MEM_DEPTH)) begin
            rdata = mem[ridx];
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB4 register-backed memory completer with wait states
// Answers pselx[SLAVE_ID], stores data in an apb_slave_mem_array and stretches
// the access phase by WAIT_CYCLES. Out-of-range or misaligned accesses return
// pslverr. Optional macro APB_SLAVE_MEM_PROT_CHECK_EN makes word indices at or
// above PROT_BASE reject accesses with pprot[0]=0.
// Ports:
//   pclk, preset                 clock, synchronous active-high reset
//   pselx, penable, pwrite       APB control
//   paddr, pwdata, pstrb, pprot  APB address, write data, lanes, protection
//   pready, prdata, pslverr      registered APB response
module apb_slave_mem #(
    parameter int ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = apb_global_pkg::DATA_WIDTH,
    parameter int NO_OF_SLAVES  = apb_global_pkg::NO_OF_SLAVES,
    parameter int SLAVE_ID      = 0,
    parameter int MEM_DEPTH     = 16,
    parameter int WAIT_CYCLES   = 0,
    parameter int PROT_BASE     = 8
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [NO_OF_SLAVES-1:0]  pselx,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    input  logic [DATA_WIDTH/8-1:0]  pstrb,
    input  logic [2:0]               pprot,
    output logic                     pready,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pslverr
);

    import apb_global_pkg::*;

    localparam int LSB   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT_CYCLES + 1);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);

    apb_slave_state_e   state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx_q;
    logic               write_q;
    logic               err_q;

    logic                     sel;
    logic [ADDRESS_WIDTH-1:0] word_idx;
    logic                     err_now;
    logic [IDX_W-1:0]         resp_idx;
    logic                     resp_err;
    logic                     resp_write;
    logic                     enter_ready;
    logic                     mem_we;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic                     unused_bits;

    assign sel      = pselx[SLAVE_ID];
    assign word_idx = paddr >> LSB;

    always_comb begin
        err_now = (word_idx >= ADDRESS_WIDTH'(MEM_DEPTH)) || ((paddr & ALIGN_MASK) != '0);
`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
        err_now = err_now || ((word_idx >= ADDRESS_WIDTH'(PROT_BASE)) && !pprot[0]);
`endif
    end

    // Other select bits belong to sibling completers; pprot is only partly
    // used even with the protection check.
    assign unused_bits = ^{pselx, pprot, 32'(PROT_BASE)};

    // A zero-wait transfer enters READY on the setup edge itself, so the
    // response must come from the live bus rather than the latched copy.
    assign resp_idx   = (state == IDLE) ? IDX_W'(word_idx) : idx_q;
    assign resp_err   = (state == IDLE) ? err_now : err_q;
    assign resp_write = (state == IDLE) ? pwrite : write_q;

    assign enter_ready = ((state == IDLE) && sel && !penable && (WAIT_CYCLES == 0)) ||
                         ((state == WAIT) && sel && (cnt == '0));

    // pwdata/pstrb are taken at the completion edge, address/error at setup.
    assign mem_we = (state == READY) && sel && penable && write_q && !err_q;

    apb_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (pclk),
        .rst   (preset),
        .we    (mem_we),
        .widx  (idx_q),
        .wdata (pwdata),
        .wstrb (pstrb),
        .ridx  (resp_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel && !penable) begin
                        idx_q   <= IDX_W'(word_idx);
                        write_q <= pwrite;
                        err_q   <= err_now;
                        if (WAIT_CYCLES == 0) begin
                            state <= READY;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!sel) begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= READY;
                    end
                end
                READY: begin
                    // Completion and a dropped select both close the transfer;
                    // only completion may have written (via mem_we).
                    if (!sel || penable) begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (enter_ready) begin
                pready  <= 1'b1;
                pslverr <= resp_err;
                if (!resp_write) begin
                    prdata <= resp_err ? '0 : rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - self-checking bench for apb_slave_mem
module tb_apb_slave_mem;

    logic        clk;
    logic        preset;
    logic [1:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready0, pready1;
    logic [31:0] prdata0, prdata1;
    logic        pslverr0, pslverr1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] mem_m [2][16];

    apb_slave_mem #(
        .ADDRESS_WIDTH (32), .DATA_WIDTH (32), .NO_OF_SLAVES (2), .SLAVE_ID (0),
        .MEM_DEPTH (16), .WAIT_CYCLES (0), .PROT_BASE (8)
    ) dut0 (
        .pclk (clk), .preset (preset), .pselx (pselx), .penable (penable),
        .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb),
        .pprot (pprot), .pready (pready0), .prdata (prdata0), .pslverr (pslverr0)
    );

    apb_slave_mem #(
        .ADDRESS_WIDTH (32), .DATA_WIDTH (32), .NO_OF_SLAVES (2), .SLAVE_ID (1),
        .MEM_DEPTH (16), .WAIT_CYCLES (3), .PROT_BASE (8)
    ) dut1 (
        .pclk (clk), .preset (preset), .pselx (pselx), .penable (penable),
        .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .pstrb (pstrb),
        .pprot (pprot), .pready (pready1), .prdata (prdata1), .pslverr (pslverr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_err(input logic [31:0] a, input logic [2:0] pr);
        logic e;
        e = ((a >> 2) >= 32'd16) || (a[1:0] != 2'b00);
`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
        e = e || (((a >> 2) >= 32'd8) && !pr[0]);
`else
        e = e || (pr === 3'bxxx);
`endif
        return e;
    endfunction

    function automatic logic [31:0] exp_read(input int s, input logic [31:0] a, input logic [2:0] pr);
        if (exp_err(a, pr)) return 32'h0;
        return mem_m[s][a[5:2]];
    endfunction

    function automatic int exp_waits(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    task automatic model_write(input int s, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] st, input logic [2:0] pr);
        if (!exp_err(a, pr)) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) mem_m[s][a[5:2]][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++) mem_m[s][i] = 32'h0;
    endtask

    // Starts at posedge+1 and returns at posedge+1 after the completion edge
    // with the bus idle, so consecutive calls are back-to-back.
    task automatic apb_xfer(input int s, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] st, input logic [2:0] pr,
                            output logic [31:0] rd, output logic er, output int waits);
        pselx   = 2'(1 << s);
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        pstrb   = st;
        pprot   = pr;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        rd = '0;
        er = 1'b0;
        forever begin
            @(negedge clk);
            if (((s == 0) ? pready0 : pready1) === 1'b1) begin
                rd = (s == 0) ? prdata0 : prdata1;
                er = (s == 0) ? pslverr0 : pslverr1;
                break;
            end
            waits++;
            if (waits > 40) begin
                checks++;
                failures++;
                $display("FAIL pready_timeout slave=%0d addr=%h waited=%0d required<=%0d", s, a, waits, 15);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        pselx   = '0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1; pselx = '0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pready0 !== 1'b0)   begin failures++; $display("FAIL reset_pready0 got=%b exp=0", pready0); end
        checks++; if (prdata0 !== 32'h0)  begin failures++; $display("FAIL reset_prdata0 got=%h exp=0", prdata0); end
        checks++; if (pslverr0 !== 1'b0)  begin failures++; $display("FAIL reset_pslverr0 got=%b exp=0", pslverr0); end
        checks++; if (pready1 !== 1'b0)   begin failures++; $display("FAIL reset_pready1 got=%b exp=0", pready1); end
        checks++; if (prdata1 !== 32'h0)  begin failures++; $display("FAIL reset_prdata1 got=%h exp=0", prdata1); end
        checks++; if (pslverr1 !== 1'b0)  begin failures++; $display("FAIL reset_pslverr1 got=%b exp=0", pslverr1); end
        preset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic er;
        int w;
        // zero-wait write then read
        apb_xfer(0, 1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, w);
        model_write(0, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000);
        checks++; if (w !== 0)  begin failures++; $display("FAIL zw_write_waits got=%0d exp=0", w); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL zw_write_err got=%b exp=0", er); end
        apb_xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b000, rd, er, w);
        checks++; if (w !== 0)  begin failures++; $display("FAIL zw_read_waits got=%0d exp=0", w); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL zw_read_data got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL zw_read_err got=%b exp=0", er); end
        // three wait states
        apb_xfer(1, 0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, w);
        checks++; if (w !== 3)  begin failures++; $display("FAIL wait3_waits got=%0d exp=3", w); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wait3_data got=%h exp=0", rd); end
        // byte strobes
        apb_xfer(0, 1, 32'h00, 32'h11223344, 4'hF, 3'b000, rd, er, w);
        model_write(0, 32'h00, 32'h11223344, 4'hF, 3'b000);
        apb_xfer(0, 1, 32'h00, 32'hAABBCCDD, 4'h5, 3'b000, rd, er, w);
        model_write(0, 32'h00, 32'hAABBCCDD, 4'h5, 3'b000);
        apb_xfer(0, 0, 32'h00, 32'h0, 4'hF, 3'b000, rd, er, w);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rd); end
        // out of range read
        apb_xfer(1, 0, 32'h40, 32'h0, 4'h0, 3'b001, rd, er, w);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_read_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_read_data got=%h exp=0", rd); end
        // misaligned write leaves word 0 untouched
        apb_xfer(0, 1, 32'h02, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, w);
        checks++; if (er !== 1'b1) begin failures++; $display("FAIL misaligned_err got=%b exp=1", er); end
        apb_xfer(0, 0, 32'h00, 32'h0, 4'h0, 3'b000, rd, er, w);
        checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL misaligned_nochange got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d;
        logic er;
        int w, c0;
        for (int s = 0; s < 2; s++) begin
            d = $urandom;
            c0 = cyc;
            apb_xfer(s, 1, 32'h1C, d, 4'hF, 3'b001, rd, er, w);
            model_write(s, 32'h1C, d, 4'hF, 3'b001);
            apb_xfer(s, 0, 32'h1C, 32'h0, 4'h0, 3'b001, rd, er, w);
            checks++;
            if (cyc - c0 !== 2 * (2 + exp_waits(s))) begin
                failures++;
                $display("FAIL b2b_cycles slave=%0d got=%0d exp=%0d", s, cyc - c0, 2 * (2 + exp_waits(s)));
            end
            checks++;
            if (rd !== exp_read(s, 32'h1C, 3'b001)) begin
                failures++;
                $display("FAIL b2b_data slave=%0d got=%h exp=%h", s, rd, exp_read(s, 32'h1C, 3'b001));
            end
        end
    endtask

    task automatic test_sel_drop();
        logic [31:0] rd;
        logic er;
        int w;
        pselx = 2'b10; penable = 0; pwrite = 1; paddr = 32'h0C;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        pselx = '0; penable = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (pready1 !== 1'b0) begin failures++; $display("FAIL seldrop_pready got=%b exp=0", pready1); end
        @(posedge clk); #1;
        apb_xfer(1, 0, 32'h0C, 32'h0, 4'h0, 3'b001, rd, er, w);
        checks++; if (w !== 3) begin failures++; $display("FAIL seldrop_next_waits got=%0d exp=3", w); end
        checks++;
        if (rd !== exp_read(1, 32'h0C, 3'b001)) begin
            failures++;
            $display("FAIL seldrop_nowrite got=%h exp=%h", rd, exp_read(1, 32'h0C, 3'b001));
        end
    endtask

    task automatic test_prot();
        logic [31:0] rd;
        logic er;
        int w;
        apb_xfer(0, 1, 32'h20, 32'h5A5A0001, 4'hF, 3'b000, rd, er, w);
        checks++; if (er !== exp_err(32'h20, 3'b000)) begin failures++; $display("FAIL prot_unpriv_err got=%b exp=%b", er, exp_err(32'h20, 3'b000)); end
        model_write(0, 32'h20, 32'h5A5A0001, 4'hF, 3'b000);
        apb_xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, w);
        checks++; if (rd !== exp_read(0, 32'h20, 3'b001)) begin failures++; $display("FAIL prot_unpriv_drop got=%h exp=%h", rd, exp_read(0, 32'h20, 3'b001)); end
        apb_xfer(0, 1, 32'h20, 32'h0BADC0DE, 4'hF, 3'b001, rd, er, w);
        checks++; if (er !== 1'b0) begin failures++; $display("FAIL prot_priv_err got=%b exp=0", er); end
        model_write(0, 32'h20, 32'h0BADC0DE, 4'hF, 3'b001);
        apb_xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, w);
        checks++; if (rd !== 32'h0BADC0DE) begin failures++; $display("FAIL prot_priv_readback got=%h exp=0badc0de", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, e_rd;
        logic [3:0] st;
        logic [2:0] pr;
        logic er, wr, e_err;
        int w, s, kind;
        for (int i = 0; i < 60; i++) begin
            s    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            a    = 32'($urandom_range(0, 15)) * 32'd4;
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            if (kind == 1) a = 32'($urandom_range(16, 40)) * 32'd4;
            if (kind == 2) a = $urandom;
            d     = $urandom;
            st    = 4'($urandom_range(0, 15));
            pr    = 3'($urandom_range(0, 7));
            e_err = exp_err(a, pr);
            e_rd  = exp_read(s, a, pr);
            apb_xfer(s, wr, a, d, st, pr, rd, er, w);
            checks++;
            if (w !== exp_waits(s)) begin
                failures++;
                $display("FAIL rand_waits i=%0d slave=%0d got=%0d exp=%0d", i, s, w, exp_waits(s));
            end
            checks++;
            if (er !== e_err) begin
                failures++;
                $display("FAIL rand_err i=%0d addr=%h got=%b exp=%b", i, a, er, e_err);
            end
            if (!wr) begin
                checks++;
                if (rd !== e_rd) begin
                    failures++;
                    $display("FAIL rand_rdata i=%0d slave=%0d addr=%h got=%h exp=%h", i, s, a, rd, e_rd);
                end
            end else begin
                model_write(s, a, d, st, pr);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic er;
        int w;
        pselx = 2'b10; penable = 0; pwrite = 1; paddr = 32'h10;
        pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        pselx = '0; penable = 1'b0;
        model_clear();
        @(negedge clk);
        checks++; if (pready1 !== 1'b0)  begin failures++; $display("FAIL rstwait_pready got=%b exp=0", pready1); end
        checks++; if (pslverr1 !== 1'b0) begin failures++; $display("FAIL rstwait_pslverr got=%b exp=0", pslverr1); end
        checks++; if (prdata1 !== 32'h0) begin failures++; $display("FAIL rstwait_prdata got=%h exp=0", prdata1); end
        @(posedge clk); #1;
        apb_xfer(1, 0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, w);
        checks++; if (w !== 3)      begin failures++; $display("FAIL rstwait_next_waits got=%0d exp=3", w); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstwait_cleared1 got=%h exp=0", rd); end
        apb_xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, w);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstwait_cleared0 got=%h exp=0", rd); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_sel_drop();
        test_prot();
        test_random();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- Parametrised, register-backed APB4 slave completer, one instance per pselx bit on the shared APB bus.
- Decodes its own select bit and stores data in a byte-strobed word array.
- Inserts a configurable number of wait states and reports pslverr on bad accesses.
- Serves as the synthesisable reference slave for the hdl_top bench and as the next-generation replacement for bare pin-level slave stubs.

Parameters:
- ADDRESS_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width; one of 8/16/32/64.
- NO_OF_SLAVES, 1, width of pselx.
- SLAVE_ID, 0, index of the pselx bit this instance answers; must be < NO_OF_SLAVES.
- MEM_DEPTH, 16, number of DATA_WIDTH words; must be >= 1.
- WAIT_CYCLES, 0, pready-low cycles in the access phase; range 0..15.
- PROT_BASE, 8, first word index of the privileged region (used only with the optional feature).

Ports:
- pclk  input  1  bus clock; all logic on rising edge.
- preset  input  1  reset; synchronous, active-high.
- pselx  input  NO_OF_SLAVES  slave selects; only bit SLAVE_ID is used.
- penable  input  1  access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDRESS_WIDTH  byte address.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte lanes.
- pprot  input  3  protection; bit0 = privileged.
- pready  output  1  transfer complete.
- prdata  output  DATA_WIDTH  read data.
- pslverr  output  1  transfer error, valid only while pready=1.

Behaviour:
- Reset (preset=1 at an edge):
  - pready=0, prdata=0, pslverr=0.
  - FSM returns to IDLE; wait counter = 0.
  - All memory words cleared to 0.
  - Reset mid-transfer aborts the transfer; no write commits.
- Definitions:
  - sel = pselx[SLAVE_ID]; LSB = log2(DATA_WIDTH/8).
  - word index = paddr[ADDRESS_WIDTH-1:LSB].
  - err = (index >= MEM_DEPTH) or (paddr[LSB-1:0] != 0), computed at the setup edge and held for the transfer.
- FSM states IDLE, WAIT, READY. pready, prdata and pslverr are registered outputs.
- IDLE, setup detected (sel=1, penable=0):
  - Latch index, pwrite, err.
  - If WAIT_CYCLES=0: go to READY; pready<=1 for the first access cycle (zero-wait).
  - Else: go to WAIT with cnt<=WAIT_CYCLES-1; pready stays 0.
- WAIT:
  - cnt!=0: decrement.
  - cnt==0: go to READY with pready<=1.
- Response data and error are loaded on the edge entering READY:
  - Read, no error: prdata<=mem[index].
  - Read with error: prdata<=0.
  - pslverr<=err.
- READY, edge with sel=1 and penable=1 (completion):
  - Write without error: commit bytes whose pstrb bit is 1.
  - Write with error, or pstrb=0: no memory change.
  - pready<=0, pslverr<=0; prdata holds its value; go to IDLE.
- Back-to-back transfers: a setup cycle immediately after completion is accepted from IDLE, giving a minimum 2-cycle transfer.
- Total access-phase latency = WAIT_CYCLES+1 cycles.
- sel dropped in WAIT or READY (protocol violation): abort with no write; clear pready and pslverr; return to IDLE.
- Changes to paddr/pwdata/pstrb after the setup edge are ignored for address and error; pwdata and pstrb are sampled at the completion edge.
- pstrb is ignored on reads. pprot is ignored unless the optional feature is enabled.

Optional Feature:
- Macro: APB_SLAVE_MEM_PROT_CHECK_EN.
- Defined: err additionally set when index >= PROT_BASE and pprot[0]=0. Unprivileged accesses to that region then return pslverr=1; reads return prdata=0; writes are dropped.
- Undefined: pprot unused; the whole array is accessible; PROT_BASE has no effect.

Decomposition:
- apb_global_pkg (shared package) holds:
  - existing ADDRESS_WIDTH, DATA_WIDTH, NO_OF_SLAVES;
  - new typedef enum apb_slave_state_e {IDLE, WAIT, READY};
  - constant MAX_WAIT_CYCLES = 15.
- One sub-module, apb_slave_mem_array:
  - synchronous-reset word array with per-byte write enable;
  - combinational read port by index;
  - the parent holds the FSM, counter and error logic.

Test Plan:
- Write 0xDEADBEEF to 0x04 (pstrb=0xF, WAIT_CYCLES=0), then read 0x04 -> pready high on the first access cycle; prdata=0xDEADBEEF; pslverr=0.
- WAIT_CYCLES=3: read 0x08 -> pready low for exactly 3 access cycles, high on the 4th; prdata=0.
- Word 0x0 holds 0x11223344; write 0xAABBCCDD with pstrb=0x5 -> read returns 0x11BB33DD.
- Read 0x40 with MEM_DEPTH=16 -> pslverr=1, prdata=0. Write 0x02 (misaligned) -> pslverr=1, memory unchanged.
- preset=1 asserted while in WAIT -> next cycle pready=0, FSM in IDLE; a following read of any word returns 0.
- With APB_SLAVE_MEM_PROT_CHECK_EN: write to 0x20 (index 8) with pprot=3'b000 -> pslverr=1, data dropped. Same write with pprot=3'b001 -> pslverr=0; read-back matches.
